rgb_stream_gen: RTL and testbench
=================================

# rgb_stream_gen

Source of the 26-bit pixel stream consumed by every overlay stage (ball, paddles, score) in the pong pipeline. Free-running horizontal/vertical counters produce VGA 640x480@60 timing (25 MHz pixel clock). Each cycle the block emits one stream word carrying Active, VS, HS, pixel coordinates and a background colour. It sits at the head of the overlay chain; downstream stages only copy or modify the word.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, level of HS during the sync pulse (0 = active-low)
- VS_POL, 0, level of VS during the sync pulse
- px_clk  input  1  pixel clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- en  input  1  advance enable; low freezes counters and output
- bg_rgb  input  3  background colour {B,G,R} for visible pixels
- RGBStr_o  output  26  stream word: [0] Active, [1] VS, [2] HS, [12:3] YC, [22:13] XC, [23] R, [24] G, [25] B
- frame_start  output  1  one-cycle pulse aligned with the stream word for (0,0)

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024 (10-bit counters).
- Horizontal counter hc runs 0..H_TOTAL-1 and wraps to 0. On that wrap, vertical counter vc increments. vc wraps from V_TOTAL-1 to 0 on the same cycle hc wraps.
- Counters advance only when en=1. With en=0, hc, vc, RGBStr_o and frame_start hold their values; frame_start is not re-pulsed while held.
- Word fields derived from the current (hc, vc):
  - XC = hc, YC = vc. Raw counter values are emitted during blanking too.
  - Active = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - HS = HS_POL when H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~HS_POL.
  - VS = VS_POL when V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~VS_POL. VS depends only on vc, so it changes on line boundaries.
  - RGB = bg_rgb when Active, else 3'b000. Blanking must be black for downstream overlays.
- frame_start = 1 exactly when the registered word has hc=0 and vc=0.
- Reset (reset_n=0 at an edge): hc=0, vc=0. RGBStr_o gets Active=0, HS=~HS_POL, VS=~VS_POL, XC=0, YC=0, RGB=0. frame_start=0.
- Reset mid-frame aborts the frame. Timing restarts at (0,0) and no partial sync pulse is extended; HS/VS go inactive on the reset edge. Reset has priority over en.

## Timing
- Fully registered output: RGBStr_o and frame_start are registered from (hc, vc) sampled at the same edge. Latency is one cycle counter→word, and all fields in a word are mutually aligned.
- First edge with reset_n=1 and en=1: word = (XC=0, YC=0, Active=1, RGB=bg_rgb), frame_start=1. hc becomes 1.
- Line period is H_TOTAL enabled cycles. Frame period is H_TOTAL×V_TOTAL = 420000 enabled cycles.
- bg_rgb is sampled at the edge that registers the word; a change shows on the next word.

## Test plan
- Reset release with en=1: word0 XC=0, YC=0, Active=1, HS=1, VS=1, frame_start=1. Next word XC=1 with frame_start=0.
- One line, en=1: Active high for words XC 0..639 and low for 640..799. HS=0 for exactly XC 656..751 (96 words). After XC=799 comes XC=0, YC=1.
- Full frame: VS=0 for all words with YC 490..491 (1600 words). Exactly one frame_start per 420000 words. After (799,524) comes (0,0).
- en toggling: hold en=0 for 5 cycles at XC=100. Output frozen at XC=100; resumes at XC=101 with no skipped or duplicated coordinate.
- Reset at (700, 491), inside HS and VS: next word is the reset value (HS=1, VS=1, Active=0). After release, restart at (0,0) with frame_start=1.
- Colour/blanking: bg_rgb=3'b101 gives RGB=101 at (639,479) and 000 at (640,479) and (0,480). Change bg_rgb to 010 at XC=10; it appears on word XC=11.

Source files
------------

// File: rtl/rgb_stream_gen_if.sv
// Stream-side bundle for rgb_stream_gen: advance enable and background colour in,
// 26-bit pixel word and frame marker out.
interface rgb_stream_gen_if;
  logic        en;
  logic [2:0]  bg_rgb;
  logic [25:0] RGBStr_o;
  logic        frame_start;

  modport master (input en, input bg_rgb, output RGBStr_o, output frame_start);
  modport slave  (output en, output bg_rgb, input RGBStr_o, input frame_start);
endinterface

// File: rtl/rgb_stream_gen.sv
// Head of the pong overlay chain: free-running VGA counters turned into a fully
// registered stream word {B,G,R,XC,YC,HS,VS,Active} plus a frame-start pulse.
module rgb_stream_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0
) (
  input  logic             px_clk,
  input  logic             reset_n,
  rgb_stream_gen_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit bounds so a sync pulse ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [25:0] RESET_WORD = {3'b000, 10'd0, 10'd0, ~HS_POL, ~VS_POL, 1'b0};

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [9:0]  hc_next;
  logic [9:0]  vc_next;
  logic        active;
  logic        hs;
  logic        vs;
  logic [2:0]  rgb;
  logic        at_origin;
  logic [25:0] word_d;
  logic [25:0] word_q;
  logic        frame_start_q;

  always_comb begin
    hc_next   = hc + 10'd1;
    vc_next   = vc;
    active    = 1'b0;
    hs        = ~HS_POL;
    vs        = ~VS_POL;
    rgb       = 3'b000;
    at_origin = 1'b0;
    word_d    = RESET_WORD;

    if ({1'b0, hc} == H_LAST) begin
      hc_next = 10'd0;
      vc_next = ({1'b0, vc} == V_LAST) ? 10'd0 : vc + 10'd1;
    end

    active = ({1'b0, hc} < H_VIS) && ({1'b0, vc} < V_VIS);
    if (({1'b0, hc} >= HS_START) && ({1'b0, hc} < HS_END)) hs = HS_POL;
    if (({1'b0, vc} >= VS_START) && ({1'b0, vc} < VS_END)) vs = VS_POL;
    // Blanking is forced black so overlays never see colour outside the visible area
    if (active) rgb = bus.bg_rgb;
    at_origin = (hc == 10'd0) && (vc == 10'd0);

    word_d = {rgb, hc, vc, hs, vs, active};
  end

  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      hc            <= 10'd0;
      vc            <= 10'd0;
      word_q        <= RESET_WORD;
      frame_start_q <= 1'b0;
    end else if (bus.en) begin
      hc            <= hc_next;
      vc            <= vc_next;
      word_q        <= word_d;
      frame_start_q <= at_origin;
    end
  end

  assign bus.RGBStr_o    = word_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb_stream_gen.sv
// Directed bench: full-size instance for line timing, enable freeze and colour;
// shrunken instance (15x8 frame) for vertical sync, frame wrap and mid-sync reset.
module tb_rgb_stream_gen;

  logic px_clk;
  logic reset_n_a;
  logic reset_n_b;

  rgb_stream_gen_if bus_a ();
  rgb_stream_gen_if bus_b ();

  rgb_stream_gen dut_a (
    .px_clk  (px_clk),
    .reset_n (reset_n_a),
    .bus     (bus_a)
  );

  rgb_stream_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .px_clk  (px_clk),
    .reset_n (reset_n_b),
    .bus     (bus_b)
  );

  initial px_clk = 1'b0;
  always #20 px_clk = ~px_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] w;
  logic [25:0] held;
  int bad_xc, bad_yc, vs_low, act_cnt, hs_cnt, fs_cnt, frz_bad, seq_bad;
  int hs_first, hs_last, ex_x, ex_y, found;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel_b, input logic rst_n, input logic en, input logic [2:0] bg);
    if (sel_b) begin
      reset_n_b    = rst_n;
      bus_b.en     = en;
      bus_b.bg_rgb = bg;
    end else begin
      reset_n_a    = rst_n;
      bus_a.en     = en;
      bus_a.bg_rgb = bg;
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b101);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b101);
    tick();
    tick();
    checkOutput("a_reset_word", bus_a.RGBStr_o, 32'd6);
    checkOutput("a_reset_fs", bus_a.frame_start, 0);
    checkOutput("b_reset_word", bus_b.RGBStr_o, 32'd6);

    // ---------------- full-size instance: one line ----------------
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b101);
    bad_xc = 0; bad_yc = 0; vs_low = 0; act_cnt = 0; hs_cnt = 0; fs_cnt = 0;
    hs_first = 1023; hs_last = 0;
    for (int x = 0; x < 800; x++) begin
      tick();
      w = bus_a.RGBStr_o;
      if (w[22:13] != 10'(x)) bad_xc++;
      if (w[12:3] != 10'd0) bad_yc++;
      if (!w[1]) vs_low++;
      if (w[0]) act_cnt++;
      if (bus_a.frame_start) fs_cnt++;
      if (!w[2]) begin
        hs_cnt++;
        if (hs_first == 1023) hs_first = int'(w[22:13]);
        hs_last = int'(w[22:13]);
      end
      if (x == 0) begin
        checkOutput("w0_xc", w[22:13], 0);
        checkOutput("w0_active", w[0], 1);
        checkOutput("w0_hs", w[2], 1);
        checkOutput("w0_vs", w[1], 1);
        checkOutput("w0_rgb", w[25:23], 3'b101);
        checkOutput("w0_fs", bus_a.frame_start, 1);
      end
      if (x == 1) begin
        checkOutput("w1_xc", w[22:13], 1);
        checkOutput("w1_fs", bus_a.frame_start, 0);
      end
      if (x == 10) begin
        checkOutput("rgb_x10", w[25:23], 3'b101);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b010);
      end
      if (x == 11) checkOutput("rgb_x11", w[25:23], 3'b010);
      if (x == 100) begin
        held = w;
        frz_bad = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010);
        repeat (5) begin
          tick();
          if (bus_a.RGBStr_o !== held || bus_a.frame_start !== 1'b0) frz_bad++;
        end
        checkOutput("freeze_x100", frz_bad, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b010);
      end
      if (x == 101) checkOutput("resume_x101", w[22:13], 101);
      if (x == 639) begin
        checkOutput("rgb_x639", w[25:23], 3'b010);
        checkOutput("act_x639", w[0], 1);
      end
      if (x == 640) begin
        checkOutput("rgb_x640", w[25:23], 3'b000);
        checkOutput("act_x640", w[0], 0);
      end
    end
    checkOutput("line_xc_seq", bad_xc, 0);
    checkOutput("line_yc0", bad_yc, 0);
    checkOutput("line_vs_low", vs_low, 0);
    checkOutput("line_active_cnt", act_cnt, 640);
    checkOutput("line_hs_cnt", hs_cnt, 96);
    checkOutput("line_hs_first", hs_first, 656);
    checkOutput("line_hs_last", hs_last, 751);
    checkOutput("line_fs_cnt", fs_cnt, 1);
    tick();
    checkOutput("wrap_xc", bus_a.RGBStr_o[22:13], 0);
    checkOutput("wrap_yc", bus_a.RGBStr_o[12:3], 1);
    checkOutput("wrap_fs", bus_a.frame_start, 0);

    // reset mid-line inside HS
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      if (bus_a.RGBStr_o[22:13] == 10'd700) found = 1;
      else tick();
    end
    checkOutput("a_find_x700", found, 1);
    checkOutput("a_x700_hs", bus_a.RGBStr_o[2], 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010);
    tick();
    checkOutput("a_midreset_word", bus_a.RGBStr_o, 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b010);
    tick();
    checkOutput("a_restart_xy", {bus_a.RGBStr_o[22:13], bus_a.RGBStr_o[12:3]}, 0);
    checkOutput("a_restart_fs", bus_a.frame_start, 1);

    // ---------------- shrunken instance: two frames ----------------
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b101);
    ex_x = 0; ex_y = 0; seq_bad = 0; fs_cnt = 0; vs_low = 0;
    for (int i = 0; i < 240; i++) begin
      tick();
      w = bus_b.RGBStr_o;
      if (w[22:13] != 10'(ex_x) || w[12:3] != 10'(ex_y)) seq_bad++;
      if (bus_b.frame_start) fs_cnt++;
      if (!w[1]) vs_low++;
      if (i < 120 && ex_x == 7 && ex_y == 3) checkOutput("b_rgb_7_3", w[25:23], 3'b101);
      if (i < 120 && ex_x == 8 && ex_y == 3) checkOutput("b_rgb_8_3", w[25:23], 3'b000);
      if (i < 120 && ex_x == 0 && ex_y == 4) checkOutput("b_rgb_0_4", w[25:23], 3'b000);
      if (i == 120) checkOutput("b_frame_wrap_fs", bus_b.frame_start, 1);
      ex_x++;
      if (ex_x == 15) begin
        ex_x = 0;
        ex_y = (ex_y + 1) % 8;
      end
    end
    checkOutput("b_xy_seq", seq_bad, 0);
    checkOutput("b_fs_cnt", fs_cnt, 2);
    checkOutput("b_vs_low_cnt", vs_low, 60);

    // reset inside both HS and VS
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (bus_b.RGBStr_o[22:13] == 10'd11 && bus_b.RGBStr_o[12:3] == 10'd6) found = 1;
    end
    checkOutput("b_find_11_6", found, 1);
    checkOutput("b_11_6_hs", bus_b.RGBStr_o[2], 0);
    checkOutput("b_11_6_vs", bus_b.RGBStr_o[1], 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b101);
    tick();
    checkOutput("b_midreset_word", bus_b.RGBStr_o, 32'd6);
    checkOutput("b_midreset_fs", bus_b.frame_start, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'b101);
    tick();
    checkOutput("b_restart_xy", {bus_b.RGBStr_o[22:13], bus_b.RGBStr_o[12:3]}, 0);
    checkOutput("b_restart_fs", bus_b.frame_start, 1);
    checkOutput("b_restart_rgb", bus_b.RGBStr_o[25:23], 3'b101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
